ac97_frame_tx: RTL and testbench
================================

Name: ac97_frame_tx

Overview:
- AC'97 serial-out transmitter. Assembles 256-bit AC-link frames (tag, command address/data, PCM left/right) and shifts them MSB-first on SDATA_OUT with SYNC framing.
- Consumes mixed 20-bit PCM from the sound mixer and codec register commands from the audio init sequencer.
- Emits a once-per-frame (48 kHz) strobe that the sound channels use as their sample tick.

Parameters:
- FRAME_BITS, 256, bits per AC-link frame.
- TAG_BITS, 16, slot 0 width; O_SYNC high for this many bits.
- SLOT_BITS, 20, width of slots 1..12.

Ports:
- I_CLK  in  1  AC'97 BIT_CLK (12.288 MHz); all logic on posedge.
- I_RESET_L  in  1  asynchronous, active-low reset.
- I_PCM_LEFT  in  20  left sample, two's complement.
- I_PCM_RIGHT  in  20  right sample.
- I_PCM_VALID  in  1  sample pair offered.
- O_PCM_READY  out  1  PCM holding register empty.
- I_CMD_VALID  in  1  codec register command offered.
- I_CMD_WRITE  in  1  1 = write, 0 = read.
- I_CMD_ADDR  in  7  codec register index.
- I_CMD_DATA  in  16  write data.
- O_CMD_READY  out  1  command holding register empty.
- O_SYNC  out  1  AC-link SYNC.
- O_SDATA_OUT  out  1  AC-link serial data.
- O_STROBE  out  1  one-cycle frame-load pulse.
- O_UNDERRUN  out  1  one-cycle pulse: frame loaded with no PCM pending.

Behaviour:
- Position counter p (8 bits) counts 0..255 and wraps; reset value 255.
- Load cycle: the cycle in which p==255.
  - 256-bit shift register loads the assembled frame; p becomes 0.
  - Every other cycle the shift register shifts left by 1.
- O_SDATA_OUT = shift_reg[255], registered. Frame bit 255 (tag bit 15) is driven in the cycle where p==0.
- O_SYNC is registered; it is 1 exactly while p is 0..15.
- Frame layout, MSB first:
  - tag[15] = 1.
  - tag[14] and tag[13] = command pending.
  - tag[12] and tag[11] = PCM pending.
  - tag[10:0] = 0.
  - Slot 1: bit19 = ~I_CMD_WRITE (1 = read), bits 18:12 = addr, bits 11:0 = 0.
  - Slot 2: bits 19:4 = data for a write, 0 for a read; bits 3:0 = 0.
  - Slot 3 = left, slot 4 = right.
  - Slots 5..12 = 0.
  - Any slot whose tag bit is 0 is transmitted as all zeros.
- PCM handshake:
  - Transfer occurs when I_PCM_VALID & O_PCM_READY on a posedge; the pair is latched into the holding register and O_PCM_READY goes 0 the next cycle.
  - On the load cycle, a full holding register is consumed and O_PCM_READY returns to 1 the next cycle.
  - If the holding register is empty on the load cycle: PCM tags = 0, O_UNDERRUN pulses for that cycle.
  - Holding register empty and I_PCM_VALID on the load cycle: the pair is accepted into holding, not into the current frame (frame is an underrun).
- Command handshake: identical rules with its own holding register. A command is sent in exactly one frame; no underrun flag for commands.
- O_STROBE = 1 in the cycle after each load cycle (registered), i.e. while p==0. Period is exactly 256 clocks.
- Reset (asynchronous, any time, including mid-frame):
  - p = 255; shift register = 0; both holding registers empty.
  - O_SYNC = 0, O_SDATA_OUT = 0, O_STROBE = 0, O_UNDERRUN = 0.
  - O_PCM_READY = 1, O_CMD_READY = 1.
  - First load cycle is the first posedge after deassertion; no partial frame is ever emitted.

Optional Feature:
- Macro AC97_CMD_SLOTS_EN.
- Defined: command path as above.
- Undefined: command holding register removed; O_CMD_READY tied 0; I_CMD_* ignored; tag[14:13] = 0; slots 1/2 always zero. PCM path unchanged.

Decomposition:
- ac97_pkg holds:
  - FRAME_BITS, TAG_BITS, SLOT_BITS.
  - Tag bit indices (TAG_FRAME_VALID=15, TAG_CMD_ADDR=14, TAG_CMD_DATA=13, TAG_PCM_L=12, TAG_PCM_R=11).
  - Slot start offsets.
- Sub-module ac97_frame_builder: purely combinational. Inputs are holding-register contents plus pending flags; output is the 256-bit frame vector. Keeps layout separate from the shift/handshake sequencing.

Test Plan:
- Reset release, no inputs:
  - O_SYNC high 16 cycles then low 240, repeating every 256.
  - First serial bits 1,0,0,0,0 then zeros.
  - O_UNDERRUN and O_STROBE pulse every 256 cycles.
- Offer LEFT=20'hABCDE, RIGHT=20'h12345 mid-frame:
  - O_PCM_READY drops next cycle.
  - Next frame shows tag 16'h9800, bits 56..75 = ABCDE, bits 76..95 = 12345.
  - O_UNDERRUN silent; READY returns after load.
- Continuous VALID with new value each frame: one pair consumed per frame; no underrun; O_STROBE period exactly 256.
- Command write addr 7'h02, data 16'h0808 (with AC97_CMD_SLOTS_EN):
  - Tag 16'hE000 (no PCM).
  - Slot1 = 20'h02000, slot2 = 20'h08080.
  - Next frame tag bits 14:13 = 0.
- Read addr 7'h26: slot1 = 20'hA6000, slot2 = 0.
- Assert I_RESET_L low at p==100 for 3 cycles:
  - Outputs zero immediately (async), READYs = 1.
  - After release, clean frame starts with SYNC; no held sample is transmitted.

Source files
------------

// File: rtl/ac97_pkg.sv
// ---------------------------------------------------------------------------
// ac97_pkg
// Shared constants and types for the AC'97 serial-out transmitter:
//   frame geometry, tag bit indices, slot MSB positions in the 256-bit frame
//   vector, and the packed types of the PCM and codec-command holding registers.
// Frame vector bit FRAME_BITS-1 is the first bit on the wire.
// ---------------------------------------------------------------------------
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;

    localparam int TAG_FRAME_VALID = 15;
    localparam int TAG_CMD_ADDR    = 14;
    localparam int TAG_CMD_DATA    = 13;
    localparam int TAG_PCM_L       = 12;
    localparam int TAG_PCM_R       = 11;

    // Tag bit k sits at frame bit TAG_LSB + k.
    localparam int TAG_LSB = FRAME_BITS - TAG_BITS;

    // MSB index (in the frame vector) of slot n, n = 1..12.
    function automatic int slot_msb(input int slot);
        return FRAME_BITS - 1 - TAG_BITS - (slot - 1) * SLOT_BITS;
    endfunction

    localparam int SLOT1_MSB = slot_msb(1);
    localparam int SLOT2_MSB = slot_msb(2);
    localparam int SLOT3_MSB = slot_msb(3);
    localparam int SLOT4_MSB = slot_msb(4);

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } pcm_pair_t;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [15:0] data;
    } codec_cmd_t;

endpackage

// File: rtl/ac97_frame_builder.sv
// ---------------------------------------------------------------------------
// ac97_frame_builder
// Purely combinational AC-link frame assembly. Keeps the slot layout apart
// from the shift/handshake sequencing in ac97_frame_tx.
// Ports:
//   pcm_pending_i  PCM holding register holds a pair for this frame
//   pcm_i          left/right sample pair
//   cmd_pending_i  command holding register holds a command for this frame
//   cmd_i          codec command (write flag, register index, write data)
//   frame_o        256-bit frame, bit 255 transmitted first
// Slots whose tag bit is clear are left all-zero.
// ---------------------------------------------------------------------------
import ac97_pkg::*;

module ac97_frame_builder (
    input  logic                  pcm_pending_i,
    input  pcm_pair_t             pcm_i,
    input  logic                  cmd_pending_i,
    input  codec_cmd_t            cmd_i,
    output logic [FRAME_BITS-1:0] frame_o
);

    always_comb begin
        frame_o = '0;
        frame_o[TAG_LSB + TAG_FRAME_VALID] = 1'b1;

        if (cmd_pending_i) begin
            frame_o[TAG_LSB + TAG_CMD_ADDR] = 1'b1;
            frame_o[TAG_LSB + TAG_CMD_DATA] = 1'b1;
            // Slot 1 bit 19 flags a read.
            frame_o[SLOT1_MSB -: SLOT_BITS] = {~cmd_i.write, cmd_i.addr, 12'h000};
            frame_o[SLOT2_MSB -: SLOT_BITS] = cmd_i.write ? {cmd_i.data, 4'h0} : '0;
        end

        if (pcm_pending_i) begin
            frame_o[TAG_LSB + TAG_PCM_L] = 1'b1;
            frame_o[TAG_LSB + TAG_PCM_R] = 1'b1;
            frame_o[SLOT3_MSB -: SLOT_BITS] = pcm_i.left;
            frame_o[SLOT4_MSB -: SLOT_BITS] = pcm_i.right;
        end
    end

endmodule

// File: rtl/ac97_frame_tx.sv
// ---------------------------------------------------------------------------
// ac97_frame_tx
// AC'97 serial-out transmitter. Holds one PCM pair and one codec command,
// assembles a 256-bit frame on the load cycle (position 255) and shifts it
// out MSB-first on O_SDATA_OUT with O_SYNC high for the 16 tag bits.
// Ports:
//   I_CLK, I_RESET_L               BIT_CLK, async active-low reset
//   I_PCM_LEFT/RIGHT/VALID         PCM pair offer; O_PCM_READY = holding empty
//   I_CMD_VALID/WRITE/ADDR/DATA    codec command offer; O_CMD_READY = holding empty
//   O_SYNC, O_SDATA_OUT            AC-link outputs
//   O_STROBE                       one pulse per frame (position 0)
//   O_UNDERRUN                     pulses with O_STROBE when the frame had no PCM
// Build option: define AC97_CMD_SLOTS_EN to include the command path; without
// it O_CMD_READY is 0, the I_CMD_* inputs are ignored and slots 1/2 stay zero.
// ---------------------------------------------------------------------------
import ac97_pkg::*;

module ac97_frame_tx (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic [19:0] I_PCM_LEFT,
    input  logic [19:0] I_PCM_RIGHT,
    input  logic        I_PCM_VALID,
    output logic        O_PCM_READY,
    input  logic        I_CMD_VALID,
    input  logic        I_CMD_WRITE,
    input  logic [6:0]  I_CMD_ADDR,
    input  logic [15:0] I_CMD_DATA,
    output logic        O_CMD_READY,
    output logic        O_SYNC,
    output logic        O_SDATA_OUT,
    output logic        O_STROBE,
    output logic        O_UNDERRUN
);

    logic [7:0]            pos_q, pos_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] frame;
    logic                  load;
    logic                  sync_q, sync_d;
    logic                  strobe_q;
    logic                  underrun_q;

    logic                  pcm_full_q, pcm_full_d;
    pcm_pair_t             pcm_q, pcm_d;
    logic                  pcm_accept;

    logic                  cmd_pending;
    codec_cmd_t            cmd_hold;

    assign load  = (pos_q == 8'hFF);
    assign pos_d = pos_q + 8'd1;

    // SYNC covers positions 0..15 of the frame being shifted.
    assign sync_d  = (pos_d[7:4] == 4'h0);
    assign shift_d = load ? frame : {shift_q[FRAME_BITS-2:0], 1'b0};

    // A pair arriving into an empty holding register on the load cycle is
    // kept for the next frame; the full flag only drops when nothing arrives.
    assign pcm_accept = I_PCM_VALID & ~pcm_full_q;
    assign pcm_full_d = pcm_accept | (pcm_full_q & ~load);
    assign pcm_d      = pcm_accept ? '{left: I_PCM_LEFT, right: I_PCM_RIGHT} : pcm_q;

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            pos_q      <= 8'hFF;
            shift_q    <= '0;
            sync_q     <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            pcm_full_q <= 1'b0;
            pcm_q      <= '0;
        end else begin
            pos_q      <= pos_d;
            shift_q    <= shift_d;
            sync_q     <= sync_d;
            strobe_q   <= load;
            underrun_q <= load & ~pcm_full_q;
            pcm_full_q <= pcm_full_d;
            pcm_q      <= pcm_d;
        end
    end

`ifdef AC97_CMD_SLOTS_EN
    logic       cmd_full_q, cmd_full_d;
    codec_cmd_t cmd_q, cmd_d;
    logic       cmd_accept;

    assign cmd_accept = I_CMD_VALID & ~cmd_full_q;
    assign cmd_full_d = cmd_accept | (cmd_full_q & ~load);
    assign cmd_d      = cmd_accept ? '{write: I_CMD_WRITE, addr: I_CMD_ADDR, data: I_CMD_DATA}
                                   : cmd_q;

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            cmd_full_q <= 1'b0;
            cmd_q      <= '0;
        end else begin
            cmd_full_q <= cmd_full_d;
            cmd_q      <= cmd_d;
        end
    end

    assign cmd_pending = cmd_full_q;
    assign cmd_hold    = cmd_q;
    assign O_CMD_READY = ~cmd_full_q;
`else
    logic unused_cmd;

    assign unused_cmd  = ^{I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA};
    assign cmd_pending = 1'b0;
    assign cmd_hold    = '0;
    assign O_CMD_READY = 1'b0;
`endif

    ac97_frame_builder u_builder (
        .pcm_pending_i (pcm_full_q),
        .pcm_i         (pcm_q),
        .cmd_pending_i (cmd_pending),
        .cmd_i         (cmd_hold),
        .frame_o       (frame)
    );

    assign O_PCM_READY = ~pcm_full_q;
    assign O_SYNC      = sync_q;
    assign O_SDATA_OUT = shift_q[FRAME_BITS-1];
    assign O_STROBE    = strobe_q;
    assign O_UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
module tb_ac97_frame_tx;

    localparam bit CMD_EN =
`ifdef AC97_CMD_SLOTS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        I_CLK;
    logic        I_RESET_L;
    logic [19:0] I_PCM_LEFT, I_PCM_RIGHT;
    logic        I_PCM_VALID;
    logic        O_PCM_READY;
    logic        I_CMD_VALID, I_CMD_WRITE;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY, O_SYNC, O_SDATA_OUT, O_STROBE, O_UNDERRUN;

    ac97_frame_tx dut (
        .I_CLK       (I_CLK),
        .I_RESET_L   (I_RESET_L),
        .I_PCM_LEFT  (I_PCM_LEFT),
        .I_PCM_RIGHT (I_PCM_RIGHT),
        .I_PCM_VALID (I_PCM_VALID),
        .O_PCM_READY (O_PCM_READY),
        .I_CMD_VALID (I_CMD_VALID),
        .I_CMD_WRITE (I_CMD_WRITE),
        .I_CMD_ADDR  (I_CMD_ADDR),
        .I_CMD_DATA  (I_CMD_DATA),
        .O_CMD_READY (O_CMD_READY),
        .O_SYNC      (O_SYNC),
        .O_SDATA_OUT (O_SDATA_OUT),
        .O_STROBE    (O_STROBE),
        .O_UNDERRUN  (O_UNDERRUN)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    int errors = 0;
    int checks = 0;
    int frames = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [255:0] bits;
        bit           under;
    } exp_t;

    exp_t         exp_q[$];
    logic [39:0]  pcm_hold[$];
    logic [23:0]  cmd_hold[$];
    int           edge_n;

    // Frame as a sequence of fields: tag (16), then 20-bit slots 1..12.
    // Slot n's LSB lands 240 - 20*n bits above the last transmitted bit.
    function automatic logic [255:0] exp_frame(input bit hp, input logic [39:0] pcm,
                                               input bit hc, input logic [23:0] cmd);
        logic [255:0] f;
        logic [15:0]  tag;
        logic [19:0]  s1, s2;
        tag = 16'h8000;
        if (hc) tag = tag + 16'h6000;
        if (hp) tag = tag + 16'h1800;
        f = 256'(tag) << 240;
        if (hc) begin
            s1 = (cmd[23] ? 20'h0 : 20'h80000) + (20'(cmd[22:16]) * 20'd4096);
            s2 = cmd[23] ? 20'(cmd[15:0]) * 20'd16 : 20'h0;
            f = f | (256'(s1) << 220) | (256'(s2) << 200);
        end
        if (hp) f = f | (256'(pcm[39:20]) << 180) | (256'(pcm[19:0]) << 160);
        return f;
    endfunction

    always @(posedge I_CLK or negedge I_RESET_L) begin : model
        bit          pcm_acc, cmd_acc, hp, hc;
        logic [39:0] p;
        logic [23:0] c;
        exp_t        e;
        if (!I_RESET_L) begin
            pcm_hold.delete();
            cmd_hold.delete();
            edge_n = 0;
        end else begin
            pcm_acc = I_PCM_VALID && (pcm_hold.size() == 0);
            cmd_acc = CMD_EN && I_CMD_VALID && (cmd_hold.size() == 0);
            if (edge_n % 256 == 0) begin
                hp = (pcm_hold.size() != 0);
                hc = (cmd_hold.size() != 0);
                p = hp ? pcm_hold.pop_front() : 40'h0;
                c = hc ? cmd_hold.pop_front() : 24'h0;
                e.bits  = exp_frame(hp, p, hc, c);
                e.under = !hp;
                exp_q.push_back(e);
            end
            if (pcm_acc) pcm_hold.push_back({I_PCM_LEFT, I_PCM_RIGHT});
            if (cmd_acc) cmd_hold.push_back({I_CMD_WRITE, I_CMD_ADDR, I_CMD_DATA});
            edge_n++;
        end
    end

    // ---------------- monitor ----------------
    int           mon_pos = -1;
    logic [255:0] mon_bits;
    exp_t         cur;
    bit           cur_valid = 0;

    always @(negedge I_CLK) begin
        if (!I_RESET_L) begin
            mon_pos   = -1;
            cur_valid = 0;
            exp_q.delete();
        end else begin
            if (mon_pos == 256) chk("strobe_period", 256'(O_STROBE), 256'(1));
            if (O_STROBE) begin
                if (mon_pos >= 0 && mon_pos < 256) chk("strobe_early", 256'(mon_pos), 256'(256));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_valid = 0;
                    $display("FAIL frame_expected: strobe seen with no frame loaded in model");
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1;
                    chk("underrun", 256'(O_UNDERRUN), 256'(cur.under));
                end
                mon_pos = 0;
            end else begin
                chk("underrun_idle", 256'(O_UNDERRUN), 256'(0));
            end
            if (mon_pos >= 0 && mon_pos < 256) begin
                chk("sync", 256'(O_SYNC), 256'(mon_pos < 16));
                mon_bits[255 - mon_pos] = O_SDATA_OUT;
                mon_pos++;
                if (mon_pos == 256 && cur_valid) begin
                    chk("frame", mon_bits, cur.bits);
                    frames++;
                end
            end
        end
    end

    always @(negedge I_CLK) begin
        if (I_RESET_L) begin
            chk("pcm_ready", 256'(O_PCM_READY), 256'(pcm_hold.size() == 0));
            chk("cmd_ready", 256'(O_CMD_READY), 256'(CMD_EN && cmd_hold.size() == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge I_CLK);
    endtask

    task automatic wait_strobe();
        int k = 0;
        while (!O_STROBE && k < 600) begin
            tick();
            k++;
        end
        if (k == 600) begin
            checks++;
            errors++;
            $display("FAIL strobe_wait: no strobe within 600 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sync"},      256'(O_SYNC),      256'(0));
        chk({tag, "_sdata"},     256'(O_SDATA_OUT), 256'(0));
        chk({tag, "_strobe"},    256'(O_STROBE),    256'(0));
        chk({tag, "_underrun"},  256'(O_UNDERRUN),  256'(0));
        chk({tag, "_pcm_ready"}, 256'(O_PCM_READY), 256'(1));
        chk({tag, "_cmd_ready"}, 256'(O_CMD_READY), 256'(CMD_EN));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        I_RESET_L   = 1'b0;
        I_PCM_LEFT  = '0;
        I_PCM_RIGHT = '0;
        I_PCM_VALID = 1'b0;
        I_CMD_VALID = 1'b0;
        I_CMD_WRITE = 1'b0;
        I_CMD_ADDR  = '0;
        I_CMD_DATA  = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        I_RESET_L = 1'b1;

        // Idle frames: pure underruns.
        repeat (3 * 256) tick();

        // Single pair offered mid-frame.
        wait_strobe();
        repeat (100) tick();
        I_PCM_LEFT  = 20'hABCDE;
        I_PCM_RIGHT = 20'h12345;
        I_PCM_VALID = 1'b1;
        tick();
        I_PCM_VALID = 1'b0;
        repeat (512) tick();

        // Continuous valid, data changing every cycle.
        I_PCM_VALID = 1'b1;
        repeat (4 * 256) begin
            I_PCM_LEFT  = 20'($urandom);
            I_PCM_RIGHT = 20'($urandom);
            tick();
        end
        I_PCM_VALID = 1'b0;
        repeat (300) tick();

        // Sparse random PCM and commands.
        repeat (6 * 256) begin
            I_PCM_VALID = ($urandom_range(0, 63) == 0);
            I_PCM_LEFT  = 20'($urandom);
            I_PCM_RIGHT = 20'($urandom);
            I_CMD_VALID = ($urandom_range(0, 127) == 0);
            I_CMD_WRITE = 1'($urandom);
            I_CMD_ADDR  = 7'($urandom);
            I_CMD_DATA  = 16'($urandom);
            tick();
        end
        I_PCM_VALID = 1'b0;
        I_CMD_VALID = 1'b0;
        repeat (300) tick();

        // Directed command write then read.
        wait_strobe();
        repeat (50) tick();
        I_CMD_VALID = 1'b1;
        I_CMD_WRITE = 1'b1;
        I_CMD_ADDR  = 7'h02;
        I_CMD_DATA  = 16'h0808;
        tick();
        I_CMD_VALID = 1'b0;
        repeat (300) tick();
        I_CMD_VALID = 1'b1;
        I_CMD_WRITE = 1'b0;
        I_CMD_ADDR  = 7'h26;
        I_CMD_DATA  = 16'hFFFF;
        tick();
        I_CMD_VALID = 1'b0;
        repeat (600) tick();

        // Reset at position 100 with a pair waiting in the holding register.
        wait_strobe();
        repeat (40) tick();
        I_PCM_LEFT  = 20'h55555;
        I_PCM_RIGHT = 20'hAAAAA;
        I_PCM_VALID = 1'b1;
        tick();
        I_PCM_VALID = 1'b0;
        repeat (59) tick();
        #2 I_RESET_L = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) tick();
        I_RESET_L = 1'b1;
        repeat (3 * 256 + 10) tick();

        chk("frame_count_min", 256'(frames >= 20), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
